// File: rtl/warp_context_table_pkg.sv
// ============================================================================
// warp_context_table_pkg : shared core-state and selector-state encodings
// Rev 1.0
// ============================================================================
`default_nettype none

package warp_context_table_pkg;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'd0,
        CORE_FETCH   = 3'd1,
        CORE_DECODE  = 3'd2,
        CORE_REQUEST = 3'd3,
        CORE_WAIT    = 3'd4,
        CORE_EXECUTE = 3'd5,
        CORE_UPDATE  = 3'd6,
        CORE_DONE    = 3'd7
    } corestate_t;

    typedef enum logic [1:0] {
        SEL_IDLE  = 2'd0,
        SEL_RUN   = 2'd1,
        SEL_STALL = 2'd2,
        SEL_DONE  = 2'd3
    } selstate_t;

endpackage

`default_nettype wire

// File: rtl/warp_context_table_rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational rotate-priority pick, starting after i_last
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_last,
    output logic [W-1:0] o_grant,
    output logic         o_valid
);

    // Walk from the farthest candidate back to the nearest so the nearest
    // requester after i_last (with i_last itself considered last) wins.
    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        for (int k = N; k >= 1; k--) begin
            if (i_req[(int'(i_last) + k) % N]) begin
                o_grant = W'((int'(i_last) + k) % N);
                o_valid = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/warp_context_table.sv
// ============================================================================
// warp_context_table : per-core warp context store and round-robin selector
// Rev 1.0
// ============================================================================
`default_nettype none

module warp_context_table
    import warp_context_table_pkg::*;
#(
    parameter  int NUM_WARPS = 4,
    parameter  int PC_BITS   = 8,
    localparam int WARP_BITS = $clog2(NUM_WARPS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_launch,
    input  logic [NUM_WARPS-1:0] i_launch_mask,
    input  logic                 i_ctx_save,
    input  logic [PC_BITS-1:0]   i_ctx_pc,
    input  logic [2:0]           i_ctx_state,
    input  logic                 i_ctx_mem_read_enable,
    input  logic                 i_ctx_mem_write_enable,
    input  logic                 i_switch_req,
    input  logic                 i_mem_resp_valid,
    input  logic [WARP_BITS-1:0] i_mem_resp_warp,
    output logic [WARP_BITS-1:0] o_warp_select,
    output logic                 o_select_valid,
    output logic [PC_BITS-1:0]   o_cur_pc,
    output logic [2:0]           o_cur_state,
    output logic                 o_cur_mem_read_enable,
    output logic                 o_cur_mem_write_enable,
    output logic                 o_all_done
);

    logic [PC_BITS-1:0]   r_pc    [NUM_WARPS];
    corestate_t           r_state [NUM_WARPS];
    logic [NUM_WARPS-1:0] r_rd_en;
    logic [NUM_WARPS-1:0] r_wr_en;
    logic [NUM_WARPS-1:0] r_active;
    logic [NUM_WARPS-1:0] r_waiting;
    logic [NUM_WARPS-1:0] r_done;
    logic [WARP_BITS-1:0] r_warp_select;
    selstate_t            r_sel_state;

    corestate_t           w_save_state;
    logic                 w_save;
    logic [NUM_WARPS-1:0] w_waiting_nx;
    logic [NUM_WARPS-1:0] w_done_nx;
    logic [NUM_WARPS-1:0] w_eligible;
    logic                 w_all_done;
    logic [WARP_BITS-1:0] w_grant;
    logic                 w_grant_valid;
    logic [WARP_BITS-1:0] w_launch_sel;

    assign w_save_state = corestate_t'(i_ctx_state);
    assign w_save       = i_ctx_save && (r_sel_state == SEL_RUN);

    // Status flags as they will be after this edge; the search sees these so
    // a same-cycle save or memory response affects the pick.
    always_comb begin
        w_waiting_nx = r_waiting;
        w_done_nx    = r_done;
        if (w_save) begin
            if (w_save_state == CORE_WAIT) w_waiting_nx[r_warp_select] = 1'b1;
            if (w_save_state == CORE_DONE) w_done_nx[r_warp_select]    = 1'b1;
        end
        if (i_mem_resp_valid && (int'(i_mem_resp_warp) < NUM_WARPS)) begin
            if (r_active[i_mem_resp_warp]) w_waiting_nx[i_mem_resp_warp] = 1'b0;
        end
    end

    assign w_eligible = r_active & ~w_waiting_nx & ~w_done_nx;
    assign w_all_done = ((r_active & ~w_done_nx) == '0);

    always_comb begin
        w_launch_sel = '0;
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
            if (i_launch_mask[i]) w_launch_sel = WARP_BITS'(i);
        end
    end

    rr_arbiter #(
        .N (NUM_WARPS)
    ) u_rr_arbiter (
        .i_req   (w_eligible),
        .i_last  (r_warp_select),
        .o_grant (w_grant),
        .o_valid (w_grant_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WARPS; i++) begin
                r_pc[i]    <= '0;
                r_state[i] <= CORE_IDLE;
            end
            r_rd_en       <= '0;
            r_wr_en       <= '0;
            r_active      <= '0;
            r_waiting     <= '0;
            r_done        <= '0;
            r_warp_select <= '0;
            r_sel_state   <= SEL_IDLE;
        end else if (i_launch) begin
            for (int i = 0; i < NUM_WARPS; i++) begin
                r_pc[i]    <= '0;
                r_state[i] <= CORE_IDLE;
            end
            r_rd_en       <= '0;
            r_wr_en       <= '0;
            r_active      <= i_launch_mask;
            r_waiting     <= '0;
            r_done        <= '0;
            r_warp_select <= w_launch_sel;
            r_sel_state   <= (i_launch_mask == '0) ? SEL_DONE : SEL_RUN;
        end else begin
            if (w_save) begin
                r_pc[r_warp_select]    <= i_ctx_pc;
                r_state[r_warp_select] <= w_save_state;
                if (w_save_state == CORE_DECODE) begin
                    r_rd_en[r_warp_select] <= i_ctx_mem_read_enable;
                    r_wr_en[r_warp_select] <= i_ctx_mem_write_enable;
                end
            end
            r_waiting <= w_waiting_nx;
            r_done    <= w_done_nx;

            case (r_sel_state)
                SEL_RUN: begin
                    if (i_switch_req) begin
                        if (w_grant_valid) begin
                            r_warp_select <= w_grant;
                        end else if (w_all_done) begin
                            r_sel_state <= SEL_DONE;
                        end else begin
                            r_sel_state <= SEL_STALL;
                        end
                    end
                end
                SEL_STALL: begin
                    if (w_grant_valid) begin
                        r_warp_select <= w_grant;
                        r_sel_state   <= SEL_RUN;
                    end
                end
                default: begin
                    r_sel_state <= r_sel_state;
                end
            endcase
        end
    end

    assign o_warp_select          = r_warp_select;
    assign o_select_valid         = (r_sel_state == SEL_RUN);
    assign o_all_done             = (r_sel_state == SEL_DONE);
    assign o_cur_pc               = r_pc[r_warp_select];
    assign o_cur_state            = r_state[r_warp_select];
    assign o_cur_mem_read_enable  = r_rd_en[r_warp_select];
    assign o_cur_mem_write_enable = r_wr_en[r_warp_select];

endmodule

`default_nettype wire

// File: tb/tb_warp_context_table.sv
// ============================================================================
// tb_warp_context_table : scoreboard bench with directed and random stimulus
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_warp_context_table;

    localparam int NW = 4;
    localparam int PB = 8;

    localparam int F_IDLE  = 0;
    localparam int F_RUN   = 1;
    localparam int F_STALL = 2;
    localparam int F_DONE  = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          launch;
    logic [NW-1:0] launch_mask;
    logic          ctx_save;
    logic [PB-1:0] ctx_pc;
    logic [2:0]    ctx_state;
    logic          ctx_rd;
    logic          ctx_wr;
    logic          switch_req;
    logic          resp_valid;
    logic [1:0]    resp_warp;
    logic [1:0]    warp_select;
    logic          select_valid;
    logic [PB-1:0] cur_pc;
    logic [2:0]    cur_state;
    logic          cur_rd;
    logic          cur_wr;
    logic          all_done;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int sel;
        int valid;
        int pc;
        int st;
        int rd;
        int wr;
        int ad;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: plain per-warp arrays and a coarse phase number
    int m_pc[NW];
    int m_st[NW];
    int m_rd[NW];
    int m_wr[NW];
    int m_act[NW];
    int m_wt[NW];
    int m_dn[NW];
    int m_sel;
    int m_fsm;

    always #5 clk = ~clk;

    warp_context_table #(
        .NUM_WARPS (NW),
        .PC_BITS   (PB)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .i_launch               (launch),
        .i_launch_mask          (launch_mask),
        .i_ctx_save             (ctx_save),
        .i_ctx_pc               (ctx_pc),
        .i_ctx_state            (ctx_state),
        .i_ctx_mem_read_enable  (ctx_rd),
        .i_ctx_mem_write_enable (ctx_wr),
        .i_switch_req           (switch_req),
        .i_mem_resp_valid       (resp_valid),
        .i_mem_resp_warp        (resp_warp),
        .o_warp_select          (warp_select),
        .o_select_valid         (select_valid),
        .o_cur_pc               (cur_pc),
        .o_cur_state            (cur_state),
        .o_cur_mem_read_enable  (cur_rd),
        .o_cur_mem_write_enable (cur_wr),
        .o_all_done             (all_done)
    );

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NW; i++) begin
            m_pc[i] = 0; m_st[i] = 0; m_rd[i] = 0; m_wr[i] = 0;
            m_act[i] = 0; m_wt[i] = 0; m_dn[i] = 0;
        end
        m_sel = 0;
        m_fsm = F_IDLE;
    endtask

    function automatic int elig(input int w);
        return (m_act[w] != 0 && m_wt[w] == 0 && m_dn[w] == 0) ? 1 : 0;
    endfunction

    task automatic model_step(input int l, input int mask, input int sv, input int pc,
                              input int st, input int rd, input int wr, input int sw,
                              input int rv, input int rw);
        int found;
        int any_left;
        if (l != 0) begin
            model_reset();
            m_sel = 0;
            for (int i = NW - 1; i >= 0; i--) begin
                m_act[i] = (mask >> i) & 1;
                if (m_act[i] != 0) m_sel = i;
            end
            m_fsm = (mask == 0) ? F_DONE : F_RUN;
            return;
        end
        if (m_fsm == F_RUN && sv != 0) begin
            m_pc[m_sel] = pc;
            m_st[m_sel] = st;
            if (st == 2) begin m_rd[m_sel] = rd; m_wr[m_sel] = wr; end
            if (st == 4) m_wt[m_sel] = 1;
            if (st == 7) m_dn[m_sel] = 1;
        end
        if (rv != 0 && m_act[rw] != 0) m_wt[rw] = 0;
        if ((m_fsm == F_RUN && sw != 0) || m_fsm == F_STALL) begin
            found = 0;
            for (int k = 1; k <= NW && found == 0; k++) begin
                if (elig((m_sel + k) % NW) != 0) begin
                    m_sel = (m_sel + k) % NW;
                    found = 1;
                end
            end
            if (found != 0) begin
                m_fsm = F_RUN;
            end else if (m_fsm == F_RUN) begin
                any_left = 0;
                for (int i = 0; i < NW; i++) if (m_act[i] != 0 && m_dn[i] == 0) any_left = 1;
                m_fsm = (any_left != 0) ? F_STALL : F_DONE;
            end
        end
    endtask

    // Drive one cycle at the falling edge, record the expected post-edge view,
    // and return shortly after the rising edge.
    task automatic step(input int l, input int mask, input int sv, input int pc,
                        input int st, input int rd, input int wr, input int sw,
                        input int rv, input int rw);
        exp_t e;
        @(negedge clk);
        launch      = l[0];
        launch_mask = mask[NW-1:0];
        ctx_save    = sv[0];
        ctx_pc      = pc[PB-1:0];
        ctx_state   = st[2:0];
        ctx_rd      = rd[0];
        ctx_wr      = wr[0];
        switch_req  = sw[0];
        resp_valid  = rv[0];
        resp_warp   = rw[1:0];
        model_step(l, mask, sv, pc, st, rd, wr, sw, rv, rw);
        e.sel   = m_sel;
        e.valid = (m_fsm == F_RUN) ? 1 : 0;
        e.pc    = m_pc[m_sel];
        e.st    = m_st[m_sel];
        e.rd    = m_rd[m_sel];
        e.wr    = m_wr[m_sel];
        e.ad    = (m_fsm == F_DONE) ? 1 : 0;
        exp_q.push_back(e);
        @(posedge clk);
        #3;
    endtask

    task automatic idle_inputs();
        launch = 0; launch_mask = '0; ctx_save = 0; ctx_pc = '0; ctx_state = '0;
        ctx_rd = 0; ctx_wr = 0; switch_req = 0; resp_valid = 0; resp_warp = '0;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_warp_select", int'(warp_select), e.sel);
            chk("sb_select_valid", int'(select_valid), e.valid);
            chk("sb_cur_pc", int'(cur_pc), e.pc);
            chk("sb_cur_state", int'(cur_state), e.st);
            chk("sb_cur_rd", int'(cur_rd), e.rd);
            chk("sb_cur_wr", int'(cur_wr), e.wr);
            chk("sb_all_done", int'(all_done), e.ad);
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_sel"}, int'(warp_select), 0);
        chk({tag, "_valid"}, int'(select_valid), 0);
        chk({tag, "_pc"}, int'(cur_pc), 0);
        chk({tag, "_state"}, int'(cur_state), 0);
        chk({tag, "_rd"}, int'(cur_rd), 0);
        chk({tag, "_wr"}, int'(cur_wr), 0);
        chk({tag, "_all_done"}, int'(all_done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int l, mask, sv, st, sw, rv;
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // launch 0110 and the two-save read-enable hold
        step(1, 4'b0110, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("launch_sel", int'(warp_select), 1);
        chk("launch_valid", int'(select_valid), 1);
        step(0, 0, 1, 8'h12, 2, 1, 0, 0, 0, 0);
        step(0, 0, 1, 8'h13, 5, 0, 0, 0, 0, 0);
        chk("save_pc", int'(cur_pc), 8'h13);
        chk("save_rd_hold", int'(cur_rd), 1);

        // wrap-around between warps 3 and 0
        step(1, 4'b1001, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("to_three", int'(warp_select), 3);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("wrap_zero", int'(warp_select), 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("back_three", int'(warp_select), 3);

        // both warps wait, stall, then a response for warp 2 resumes
        step(1, 4'b0110, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 8'h20, 4, 0, 0, 1, 0, 0);
        step(0, 0, 1, 8'h30, 4, 0, 0, 1, 0, 0);
        chk("stall_valid", int'(select_valid), 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
        chk("resume_sel", int'(warp_select), 2);
        chk("resume_valid", int'(select_valid), 1);

        // finish every warp, then relaunch
        step(0, 0, 1, 8'h31, 7, 0, 0, 1, 1, 1);
        step(0, 0, 1, 8'h21, 7, 0, 0, 1, 0, 0);
        chk("all_done_set", int'(all_done), 1);
        step(1, 4'b0001, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("all_done_clr", int'(all_done), 0);
        chk("relaunch_sel", int'(warp_select), 0);

        // response and wait-save for the same warp in one cycle
        step(0, 0, 1, 8'h40, 4, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("resp_wins_valid", int'(select_valid), 1);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            l    = ($urandom_range(0, 19) == 0) ? 1 : 0;
            mask = $urandom_range(0, 15);
            sv   = $urandom_range(0, 1);
            st   = $urandom_range(0, 7);
            sw   = ($urandom_range(0, 2) == 0) ? 1 : 0;
            rv   = ($urandom_range(0, 3) == 0) ? 1 : 0;
            step(l, mask, sv, $urandom_range(0, 255), st, $urandom_range(0, 1),
                 $urandom_range(0, 1), sw, rv, $urandom_range(0, 3));
            if (c == 1500) begin
                rst_n = 1'b0;
                idle_inputs();
                #1;
                chk_zero("async_reset");
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        repeat (3) @(posedge clk);
        #4;
        chk("scoreboard_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/warp_context_table.md
# warp_context_table

Per-core warp context store and round-robin warp selector. It supersedes the fixed two-warp context register, with a parametrised warp count and PC width. It holds PC, core state and decoded memory enables for every warp, tracks active/waiting/done status, and chooses the next eligible warp on a switch request. It sits between the core scheduler FSM and the decoder/LSU, and supplies the restored context of the selected warp.

## Interface
- `NUM_WARPS`, 4: warps per core, ≥2; the index width is `WARP_BITS = $clog2(NUM_WARPS)`.
- `PC_BITS`, 8: program counter width.
- `clk` input 1: single clock; all state updates on posedge.
- `reset` input 1: asynchronous, active-low; clears the whole table.
- `launch` input 1: one-cycle pulse; starts a block using `launch_mask`.
- `launch_mask` input NUM_WARPS: warps that participate in the block.
- `ctx_save` input 1: write the current context into the entry of `warp_select`.
- `ctx_pc` input PC_BITS: PC to save.
- `ctx_state` input 3 (corestate_t): core state to save.
- `ctx_mem_read_enable`, `ctx_mem_write_enable` input 1 each: decoded enables.
- `switch_req` input 1: advance to the next eligible warp.
- `mem_resp_valid` input 1: a memory response has arrived for a parked warp.
- `mem_resp_warp` input WARP_BITS: the warp that the response belongs to.
- `warp_select` output WARP_BITS: index of the current warp.
- `select_valid` output 1: `warp_select` names an eligible warp.
- `cur_pc` output PC_BITS: table PC of `warp_select`.
- `cur_state` output 3: table state of `warp_select`.
- `cur_mem_read_enable`, `cur_mem_write_enable` output 1: table enables of `warp_select`.
- `all_done` output 1: every launched warp has reached CORE_DONE.

## Operation
- Per-entry fields: pc, state, rd_en, wr_en, active, waiting, done.
- Eligible warp: active && !waiting && !done.
- Reset (async, active-low): every field is 0, state is CORE_IDLE, `warp_select` is 0. The selector FSM goes to SEL_IDLE, so `select_valid` = 0 and `all_done` = 0.
- `launch`:
  - For each i, active[i] = launch_mask[i]. pc, rd_en, wr_en, waiting and done are cleared, and state is CORE_IDLE.
  - `warp_select` takes the lowest set bit of `launch_mask`.
  - If the mask is 0, the FSM goes to SEL_DONE. Otherwise it goes to SEL_RUN.
- `ctx_save`, only in SEL_RUN:
  - pc and state are written.
  - rd_en and wr_en are written only when ctx_state == CORE_DECODE. Otherwise they hold.
  - ctx_state == CORE_WAIT sets waiting.
  - ctx_state == CORE_DONE sets done.
- `mem_resp_valid` clears waiting[mem_resp_warp]. It has no effect on an inactive warp.
- Selector FSM states: SEL_IDLE, SEL_RUN, SEL_STALL, SEL_DONE.
  - SEL_IDLE → SEL_RUN on `launch` with a non-zero mask.
  - SEL_RUN with `switch_req`:
    - Search (warp_select+1) … (warp_select+NUM_WARPS) mod NUM_WARPS, including the current warp last, and take the first eligible warp.
    - If none is eligible and all active warps are done, go to SEL_DONE.
    - If none is eligible otherwise, go to SEL_STALL.
  - SEL_STALL re-searches every cycle, starting after the last `warp_select`. It goes to SEL_RUN when a warp becomes eligible.
  - SEL_DONE: `all_done` = 1, held until `launch` or reset. A `launch` in SEL_DONE restarts the block.
- `select_valid` = 1 only in SEL_RUN.
- Eligibility is evaluated on post-update state. A save or response in the same cycle as `switch_req` is visible to that search.
- The `cur_*` outputs are a combinational read of entry `warp_select`.

## Timing
- Save latency: the written values appear on `cur_*` the cycle after the save edge.
- Switch latency: `warp_select` changes at the edge that samples `switch_req`. New `cur_*` are valid that same cycle.
- `switch_req` is ignored outside SEL_RUN.
- `ctx_save` outside SEL_RUN is ignored.
- `launch` has priority over `ctx_save`, `switch_req` and `mem_resp_valid` in the same cycle.
- Wrap-around: a search from the highest index wraps to index 0.
- A response for the warp currently being marked waiting in the same cycle: the response wins, and waiting stays 0.
- Reset asserted mid-operation: outputs go to reset values immediately, without waiting for `clk`.

## Structure
- `corestate_t` (CORE_IDLE=0 … CORE_DONE=7) lives in the shared enums package.
- `selstate_t` (SEL_IDLE, SEL_RUN, SEL_STALL, SEL_DONE) is added to the same package.
- One sub-module, `rr_arbiter`, parametrised on N:
  - inputs: request vector, last grant index.
  - outputs: grant index and grant valid.
  - purely combinational rotate-priority logic, instantiated once.

## Test plan
- Reset, then launch with mask 4'b0110. Required: `warp_select` = 1, `select_valid` = 1, `cur_pc` = 0, `cur_state` = CORE_IDLE.
- In warp 1, save pc=8'h12 with state=CORE_DECODE and rd_en=1. Then save pc=8'h13 with state=CORE_EXECUTE and rd_en=0. Required: `cur_pc` = 8'h13, `cur_mem_read_enable` still 1.
- Mask 4'b1001 with `warp_select` = 3, then `switch_req`. Required: wrap to 0 in one cycle, then back to 3 on the next request.
- Both active warps save CORE_WAIT, then `switch_req`. Required: SEL_STALL and `select_valid` = 0. Then `mem_resp_valid` with warp 2. Required: next cycle `warp_select` = 2, `select_valid` = 1.
- All active warps save CORE_DONE. Required: `all_done` = 1. A later `launch` with 4'b0001 clears `all_done` and gives `warp_select` = 0.
- Drop reset low asynchronously mid-run. Required: all outputs are 0 / CORE_IDLE before the next `clk` edge.
